// File: rtl/sag_arb_seq_if.sv
// Requester, result and handshake signals of the shared SAG engine.
interface sag_arb_seq_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_data;
  logic [7:0] req0_ctrl;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_data;
  logic [7:0] req1_ctrl;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_id;

  modport master (
    output req0_valid, req0_data, req0_ctrl,
    output req1_valid, req1_data, req1_ctrl,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_ctrl,
    input  req1_valid, req1_data, req1_ctrl,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id
  );
endinterface

// File: rtl/sag_arb_seq.sv
// Iterative 8-bit Sheep-And-Goats engine: one SAG stage reused over three passes, shared by
// two round-robin requesters. Define SAG_BACK2BACK_EN to accept the next operation from DONE.
module sag_arb_seq (
  input logic          clk,
  input logic          rst_n,
  sag_arb_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PASS1, PASS2, PASS3, DONE} state_t;

  state_t      state;
  logic [7:0]  d;
  logic [7:0]  c;
  logic [1:0]  pass_cnt;
  logic        cur_id;
  logic        last_grant;
  logic [7:0]  res_data_q;
  logic        res_id_q;
  logic        res_valid_q;

  logic [1:0]  sel;
  logic [15:0] pass_out;
  logic        win;
  logic        accept_slot;
  logic        take;
  logic [7:0]  op_data;
  logic [7:0]  op_ctrl;

  // One SAG stage: returns {new d, new c}; both operands share the same swap mask.
  function automatic logic [15:0] sag_pass(input logic [7:0] din, input logic [7:0] cin,
                                           input logic [1:0] s);
    logic [7:0] brk;
    logic [7:0] x;
    logic [3:0] t;
    logic [7:0] bd;
    logic [7:0] bc;
    logic [7:0] od;
    logic [7:0] oc;
    brk  = ({8{s[0]}} & 8'b0100_0100) | ({8{s[1]}} & 8'b0001_0000);
    x    = '0;
    x[0] = cin[0];
    for (int unsigned i = 1; i < 8; i++) begin
      x[i] = cin[i] ^ (x[i-1] & ~brk[i]);
    end
    t  = '0;
    bd = '0;
    bc = '0;
    od = '0;
    oc = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      t[j]       = ~x[2*j];
      bd[2*j]    = t[j] ? din[2*j+1] : din[2*j];
      bd[2*j+1]  = t[j] ? din[2*j]   : din[2*j+1];
      bc[2*j]    = t[j] ? cin[2*j+1] : cin[2*j];
      bc[2*j+1]  = t[j] ? cin[2*j]   : cin[2*j+1];
    end
    for (int unsigned j = 0; j < 4; j++) begin
      od[j]   = bd[2*j];
      od[j+4] = bd[2*j+1];
      oc[j]   = bc[2*j];
      oc[j+4] = bc[2*j+1];
    end
    return {od, oc};
  endfunction

  // Pass counter 0,1,2 maps to sel 00,10,11.
  assign sel      = {pass_cnt != 2'd0, pass_cnt == 2'd2};
  assign pass_out = sag_pass(d, c, sel);

  always_comb begin
    win         = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept_slot = (state == IDLE);
`ifdef SAG_BACK2BACK_EN
    accept_slot = accept_slot || ((state == DONE) && bus.res_ready);
`endif
    take           = accept_slot && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = accept_slot && bus.req0_valid && !win;
    bus.req1_ready = accept_slot && bus.req1_valid && win;
    op_data        = win ? bus.req1_data : bus.req0_data;
    op_ctrl        = win ? bus.req1_ctrl : bus.req0_ctrl;
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d           <= '0;
      c           <= '0;
      pass_cnt    <= '0;
      cur_id      <= 1'b0;
      last_grant  <= 1'b1;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            d          <= op_data;
            c          <= op_ctrl;
            cur_id     <= win;
            last_grant <= win;
            pass_cnt   <= '0;
            state      <= PASS1;
          end
        end
        PASS1: begin
          {d, c}   <= pass_out;
          pass_cnt <= pass_cnt + 2'd1;
          state    <= PASS2;
        end
        PASS2: begin
          {d, c}   <= pass_out;
          pass_cnt <= pass_cnt + 2'd1;
          state    <= PASS3;
        end
        PASS3: begin
          {d, c}      <= pass_out;
          pass_cnt    <= pass_cnt + 2'd1;
          res_data_q  <= pass_out[15:8];
          res_id_q    <= cur_id;
          res_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
`ifdef SAG_BACK2BACK_EN
            if (take) begin
              d          <= op_data;
              c          <= op_ctrl;
              cur_id     <= win;
              last_grant <= win;
              pass_cnt   <= '0;
              state      <= PASS1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sag_arb_seq.sv
// Self-checking bench for sag_arb_seq: directed cases, ties, backpressure, mid-op reset and
// randomized operations against a bit-level SAG reference model.
module tb_sag_arb_seq;

  logic clk;
  logic rst_n;
  sag_arb_seq_if bus ();

  sag_arb_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SAG_BACK2BACK_EN
  localparam int PERIOD = 4;
`else
  localparam int PERIOD = 5;
`endif

  int  n_assert = 0;
  int  n_fail   = 0;
  int  last_g   = 1;
  time t_res    = 0;
  time t_prev   = 0;

  // Three SAG stages computed from the rules with plain integer arrays.
  function automatic logic [7:0] sag_ref(input logic [7:0] din, input logic [7:0] cin);
    int dv[8];
    int cv[8];
    int x[8];
    int nd[8];
    int nc[8];
    int sels[3];
    int tmp;
    logic [7:0] r;
    sels[0] = 0; sels[1] = 2; sels[2] = 3;
    for (int i = 0; i < 8; i++) begin
      dv[i] = int'(din[i]);
      cv[i] = int'(cin[i]);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 0) x[i] = cv[0];
        else if (((sels[p] % 2) == 1 && (i == 2 || i == 6)) || (sels[p] >= 2 && i == 4))
          x[i] = cv[i];
        else
          x[i] = (cv[i] + x[i-1]) % 2;
      end
      for (int j = 0; j < 4; j++) begin
        if (x[2*j] == 0) begin
          tmp = dv[2*j]; dv[2*j] = dv[2*j+1]; dv[2*j+1] = tmp;
          tmp = cv[2*j]; cv[2*j] = cv[2*j+1]; cv[2*j+1] = tmp;
        end
      end
      for (int j = 0; j < 4; j++) begin
        nd[j] = dv[2*j]; nd[j+4] = dv[2*j+1];
        nc[j] = cv[2*j]; nc[j+4] = cv[2*j+1];
      end
      dv = nd;
      cv = nc;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = (dv[i] != 0);
    return r;
  endfunction

  function automatic int winner(input bit v0, input bit v1);
    if (v0 && v1) return (last_g == 1) ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input int w);
    chk(tag, {30'd0, bus.req1_ready, bus.req0_ready}, (w == 0) ? 32'd1 : 32'd2);
  endtask

  // Present operands at a negedge while the engine can accept, and check the grant.
  task automatic issue(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] c0,
                       input logic [7:0] d1, input logic [7:0] c1, output int w);
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_ctrl = c0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_ctrl = c1;
    #1;
    w = winner(v0, v1);
    check_grant("grant", w);
    last_g = w;
  endtask

  // Wait (bounded) for the result of the operation accepted at the coming edge.
  task automatic collect(input logic [7:0] exp_d, input int exp_id, input bit drop);
    int lat;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.res_ready = 1'b0;
      if (drop) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (bus.res_valid === 1'b1) begin
        lat = k;
        break;
      end
      chk("busy_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    end
    t_res = $time;
    chk("latency", lat, 4);
    chk("res_data", {24'd0, bus.res_data}, {24'd0, exp_d});
    chk("res_id", {31'd0, bus.res_id}, exp_id);
    chk("done_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
  endtask

  // Consume the result in DONE; keep=1 leaves both requesters valid for the next grant.
  task automatic handoff(input bit keep, output int w);
    w = 0;
`ifdef SAG_BACK2BACK_EN
    if (keep) begin
      bus.res_ready = 1'b1;
      #1;
      w = winner(1'b1, 1'b1);
      check_grant("b2b_grant", w);
      last_g = w;
      return;
    end
`endif
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("done_no_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("released", {31'd0, bus.res_valid}, 32'd0);
    if (keep) begin
      w = winner(1'b1, 1'b1);
      check_grant("idle_grant", w);
      last_g = w;
    end
  endtask

  initial begin
    int w;
    logic [7:0] hold_d;
    logic       hold_id;
    logic [7:0] rd0, rc0, rd1, rc1;
    bit         rv0, rv1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_ctrl = '0;
    bus.res_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("rst_res_data", {24'd0, bus.res_data}, 32'd0);
    chk("rst_res_id", {31'd0, bus.res_id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations
    issue(1, 0, 8'h01, 8'h00, 8'h00, 8'h00, w);
    collect(8'h80, 0, 1);
    handoff(0, w);
    issue(1, 0, 8'h0F, 8'h00, 8'h00, 8'h00, w);
    collect(8'hF0, 0, 1);
    handoff(0, w);
    issue(0, 1, 8'h00, 8'h00, 8'hA5, 8'hFF, w);
    collect(8'hA5, 1, 1);
    handoff(0, w);

    // Backpressure: result held 10 cycles while req0 waits
    issue(0, 1, 8'h00, 8'h00, 8'h5B, 8'h3D, w);
    collect(sag_ref(8'h5B, 8'h3D), 1, 1);
    hold_d  = bus.res_data;
    hold_id = bus.res_id;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp_data", {24'd0, bus.res_data}, {24'd0, hold_d});
      chk("bp_id", {31'd0, bus.res_id}, {31'd0, hold_id});
      chk("bp_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    end
    handoff(0, w);
    @(negedge clk);
    #1;
    chk("bp_single_xfer", {31'd0, bus.res_valid}, 32'd0);

    // Reset during PASS2 discards the operation
    issue(1, 0, 8'hC3, 8'h1E, 8'h00, 8'h00, w);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("midrst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("midrst_data", {24'd0, bus.res_data}, 32'd0);
    chk("midrst_id", {31'd0, bus.res_id}, 32'd0);
    last_g = 1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("no_ghost", {31'd0, bus.res_valid}, 32'd0);
    end

    // Continuous tie: grants alternate starting with requester 0
    issue(1, 1, 8'h3C, 8'h5A, 8'hC1, 8'h96, w);
    for (int n = 0; n < 4; n++) begin
      collect((w == 0) ? sag_ref(8'h3C, 8'h5A) : sag_ref(8'hC1, 8'h96), w, 0);
      if (n > 0) chk("tie_period", int'((t_res - t_prev) / 10), PERIOD);
      t_prev = t_res;
      handoff(n < 3, w);
    end

    // Randomized operations with random backpressure
    for (int r = 0; r < 12; r++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      rd0 = 8'($urandom); rc0 = 8'($urandom);
      rd1 = 8'($urandom); rc1 = 8'($urandom);
      issue(rv0, rv1, rd0, rc0, rd1, rc1, w);
      collect((w == 0) ? sag_ref(rd0, rc0) : sag_ref(rd1, rc1), w, 1);
      hold_d = bus.res_data;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        @(negedge clk);
        #1;
        chk("rand_hold", {23'd0, bus.res_valid, bus.res_data}, {23'd0, 1'b1, hold_d});
      end
      handoff(0, w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
